// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multi-cycle multiply/divide unit holding the HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IR_E,
    input  logic [31:0] RS_E,
    input  logic [31:0] RT_E,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_we;

    logic [5:0] funct;
    logic       is_r;
    logic       is_mult, is_multu, is_div, is_divu;
    logic       is_mfhi, is_mthi, is_mflo, is_mtlo;
    logic       is_md, is_mul_class;
    logic       unused_ir;

    assign funct        = IR_E[5:0];
    assign is_r         = (IR_E[31:26] == 6'h00);
    assign is_mult      = is_r && (funct == 6'h18);
    assign is_multu     = is_r && (funct == 6'h19);
    assign is_div       = is_r && (funct == 6'h1A);
    assign is_divu      = is_r && (funct == 6'h1B);
    assign is_mfhi      = is_r && (funct == 6'h10);
    assign is_mthi      = is_r && (funct == 6'h11);
    assign is_mflo      = is_r && (funct == 6'h12);
    assign is_mtlo      = is_r && (funct == 6'h13);
    assign is_mul_class = is_mult || is_multu;
    assign is_md        = is_mul_class || is_div || is_divu;
    assign unused_ir    = ^IR_E[25:6];

    assign Start  = is_md && (state == S_IDLE);
    assign Busy   = (state == S_RUN);
    assign MD_Out = is_mfhi ? HI : (is_mflo ? LO : 32'h0);

    // Divisor forced to 1 on divide-by-zero (result discarded anyway) and on
    // 0x80000000 / -1, where dividing by 1 yields exactly the required LO/HI.
    logic               div_zero, div_ovf;
    logic        [31:0] divisor_s, divisor_u;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign div_zero  = (RT_E == 32'h0);
    assign div_ovf   = (RS_E == 32'h8000_0000) && (RT_E == 32'hFFFF_FFFF);
    assign divisor_s = (div_zero || div_ovf) ? 32'd1 : RT_E;
    assign divisor_u = div_zero ? 32'd1 : RT_E;
    assign quot_s    = $signed(RS_E) / $signed(divisor_s);
    assign rem_s     = $signed(RS_E) % $signed(divisor_s);
    assign quot_u    = RS_E / divisor_u;
    assign rem_u     = RS_E % divisor_u;
    assign prod_s    = $signed({{32{RS_E[31]}}, RS_E}) * $signed({{32{RT_E[31]}}, RT_E});
    assign prod_u    = {32'h0, RS_E} * {32'h0, RT_E};

    logic [31:0] res_hi, res_lo;
    logic        res_we;

    always_comb begin
        res_hi = 32'h0;
        res_lo = 32'h0;
        res_we = 1'b0;
        if (is_mult) begin
            {res_hi, res_lo} = prod_s;
            res_we = 1'b1;
        end else if (is_multu) begin
            {res_hi, res_lo} = prod_u;
            res_we = 1'b1;
        end else if (is_div) begin
            res_hi = rem_s;
            res_lo = quot_s;
            res_we = !div_zero;
        end else if (is_divu) begin
            res_hi = rem_u;
            res_lo = quot_u;
            res_we = !div_zero;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (Start) state_next = S_RUN;
            S_RUN:   if (cnt == '0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            HI      <= 32'h0;
            LO      <= 32'h0;
            pend_hi <= 32'h0;
            pend_lo <= 32'h0;
            pend_we <= 1'b0;
            cnt     <= '0;
        end else if (state == S_IDLE) begin
            if (Start) begin
                cnt     <= is_mul_class ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_we <= res_we;
            end else if (is_mthi) begin
                HI <= RS_E;
            end else if (is_mtlo) begin
                LO <= RS_E;
            end
        end else begin
            if (cnt == '0) begin
                if (pend_we) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
